// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the pattern responder and its burst address generator.
// Contents: CTI/BTE encodings, responder FSM state type, address-derived pattern function.
package wb_pkg;

  // Cycle type identifiers
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] LINEAR = 2'b00;
  localparam logic [1:0] WRAP4  = 2'b01;
  localparam logic [1:0] WRAP8  = 2'b10;
  localparam logic [1:0] WRAP16 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StClassic,
    StBurst,
    StErr
  } wb_state_e;

  // Word-aligned address xor seed; byte offset bits never affect the pattern.
  function automatic logic [31:0] pat(input logic [31:0] adr, input logic [31:0] seed);
    return {adr[31:2], 2'b00} ^ seed;
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Combinational Wishbone incrementing-burst next-address generator.
// Ports:
//   adr_i  current byte address of the beat
//   bte_i  burst type extension (linear, wrap-4/8/16)
//   adr_o  byte address of the following beat
module wb_burst_adr_gen
  import wb_pkg::*;
(
  input  logic [31:0] adr_i,
  input  logic [1:0]  bte_i,
  output logic [31:0] adr_o
);

  logic [31:0] inc;
  logic [31:0] wrap_mask;

  always_comb begin
    inc = adr_i + 32'd4;
    case (bte_i)
      WRAP4:   wrap_mask = 32'h0000_000F;
      WRAP8:   wrap_mask = 32'h0000_001F;
      WRAP16:  wrap_mask = 32'h0000_003F;
      default: wrap_mask = 32'hFFFF_FFFF;
    endcase
    // Bits outside the wrap block keep their value; bits inside take the incremented value.
    adr_o = (adr_i & ~wrap_mask) | (inc & wrap_mask);
  end

endmodule

// File: rtl/wb_pattern_slave.sv
// Wishbone B3 pattern responder: reads return pat(addr), writes are compared against it.
// Handles classic cycles and incrementing bursts (linear, wrap-4/8/16) with registered
// feedback: ack is registered, and a beat completes on the edge where ack is high while the
// master still drives cyc&stb.
// Ports: wb_clk/wb_rst (sync, active high), Wishbone slave inputs wb_*_i, responses
// wb_dat_o/wb_ack_o/wb_err_o/wb_rty_o, status beat_count, mismatch_count,
// first_mismatch_adr, addr_seq_err.
// Optional feature: define WB_PATTERN_SLAVE_STALL_EN to drop ack for one cycle after every
// STALL_PERIOD completed burst beats.
module wb_pattern_slave
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter logic [31:0] SEED         = 32'hA5A5_0000,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] beat_count,
  output logic [15:0] mismatch_count,
  output logic [31:0] first_mismatch_adr,
  output logic        addr_seq_err
);

  localparam logic [3:0] WaitLast = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  wb_state_e   state_q;
  logic        ack_q, err_q, seq_err_q, first_q, burst_q;
  logic [31:0] dat_q, adr_q, beat_cnt_q, first_mm_q;
  logic [15:0] mm_cnt_q;
  logic [1:0]  bte_q;
  logic [3:0]  wait_cnt_q;

  logic        req, in_win, beat_done, wr_bad, seq_bad;
  logic [31:0] off, lane_mask, adr_nxt;

  wb_burst_adr_gen u_adr_gen (
    .adr_i (adr_q),
    .bte_i (bte_q),
    .adr_o (adr_nxt)
  );

  always_comb begin
    req       = wb_cyc_i & wb_stb_i;
    off       = wb_adr_i - BASE_ADDR;
    in_win    = (off >> ADDR_WIDTH) == 32'd0;
    beat_done = ack_q & req;
    lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wr_bad    = wb_we_i & (|((wb_dat_i ^ pat(adr_q, SEED)) & lane_mask));
    seq_bad   = (state_q == StBurst) & ~first_q & (wb_adr_i != adr_q);
  end

`ifdef WB_PATTERN_SLAVE_STALL_EN
  logic [7:0] stall_cnt_q;
`else
  logic [7:0] unused_stall_period;
  assign unused_stall_period = STALL_PERIOD[7:0];
`endif

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      first_q    <= 1'b0;
      burst_q    <= 1'b0;
      dat_q      <= '0;
      adr_q      <= '0;
      beat_cnt_q <= '0;
      first_mm_q <= '0;
      mm_cnt_q   <= '0;
      bte_q      <= '0;
      wait_cnt_q <= '0;
`ifdef WB_PATTERN_SLAVE_STALL_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      // Bookkeeping for a completed beat, independent of the state transition below.
      if (beat_done) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
        if (wr_bad) begin
          if (mm_cnt_q != 16'hFFFF) mm_cnt_q <= mm_cnt_q + 16'd1;
          if (mm_cnt_q == 16'd0) first_mm_q <= adr_q;
        end
        if (seq_bad) seq_err_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (req) begin
            adr_q      <= wb_adr_i;
            bte_q      <= wb_bte_i;
            burst_q    <= (wb_cti_i == INCR);
            first_q    <= 1'b1;
            wait_cnt_q <= '0;
`ifdef WB_PATTERN_SLAVE_STALL_EN
            stall_cnt_q <= '0;
`endif
            if (!in_win) begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end else if (WAIT_CYCLES > 0) begin
              state_q <= StWait;
            end else begin
              ack_q   <= 1'b1;
              dat_q   <= pat(wb_adr_i, SEED);
              state_q <= (wb_cti_i == INCR) ? StBurst : StClassic;
            end
          end
        end
        StWait: begin
          if (!wb_cyc_i) begin
            state_q <= StIdle;
          end else if (wait_cnt_q == WaitLast) begin
            ack_q   <= 1'b1;
            dat_q   <= pat(adr_q, SEED);
            state_q <= burst_q ? StBurst : StClassic;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StClassic: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= StIdle;
        end
        StBurst: begin
          if (ack_q) begin
            if (!req || wb_cti_i == EOB) begin
              ack_q   <= 1'b0;
              dat_q   <= '0;
              state_q <= StIdle;
            end else begin
              first_q <= 1'b0;
              adr_q   <= adr_nxt;
              dat_q   <= pat(adr_nxt, SEED);
`ifdef WB_PATTERN_SLAVE_STALL_EN
              // Address already points at the next beat; it is held through the stall cycle.
              if (stall_cnt_q == 8'(STALL_PERIOD - 1)) begin
                ack_q       <= 1'b0;
                stall_cnt_q <= '0;
              end else begin
                stall_cnt_q <= stall_cnt_q + 8'd1;
              end
`endif
            end
          end else begin
`ifdef WB_PATTERN_SLAVE_STALL_EN
            ack_q   <= req;
            state_q <= req ? StBurst : StIdle;
            if (!req) dat_q <= '0;
`else
            state_q <= StIdle;
`endif
          end
        end
        StErr: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_dat_o           = dat_q;
  assign wb_ack_o           = ack_q;
  assign wb_err_o           = err_q;
  assign wb_rty_o           = 1'b0;
  assign beat_count         = beat_cnt_q;
  assign mismatch_count     = mm_cnt_q;
  assign first_mismatch_adr = first_mm_q;
  assign addr_seq_err       = seq_err_q;

endmodule

// File: tb/tb_wb_pattern_slave.sv
module tb_wb_pattern_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [3:0]  m_sel;

  logic [31:0] dat_o, bc, fma;
  logic        ack, err, rty, seq;
  logic [15:0] mm;

  logic [31:0] w_dat_o, w_bc, w_fma;
  logic        w_ack, w_err, w_rty, w_seq;
  logic [15:0] w_mm;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] bus_a [8];
  logic [31:0] exp_a [8];

  always #5 clk = ~clk;

  wb_pattern_slave u_dut (
    .wb_clk (clk), .wb_rst (rst), .wb_cyc_i (m_cyc), .wb_stb_i (m_stb), .wb_we_i (m_we),
    .wb_adr_i (m_adr), .wb_dat_i (m_dat), .wb_cti_i (m_cti), .wb_bte_i (m_bte),
    .wb_sel_i (m_sel), .wb_dat_o (dat_o), .wb_ack_o (ack), .wb_err_o (err), .wb_rty_o (rty),
    .beat_count (bc), .mismatch_count (mm), .first_mismatch_adr (fma), .addr_seq_err (seq)
  );

  wb_pattern_slave #(.WAIT_CYCLES(2)) u_dut_w (
    .wb_clk (clk), .wb_rst (rst), .wb_cyc_i (m_cyc), .wb_stb_i (m_stb), .wb_we_i (m_we),
    .wb_adr_i (m_adr), .wb_dat_i (m_dat), .wb_cti_i (m_cti), .wb_bte_i (m_bte),
    .wb_sel_i (m_sel), .wb_dat_o (w_dat_o), .wb_ack_o (w_ack), .wb_err_o (w_err),
    .wb_rty_o (w_rty), .beat_count (w_bc), .mismatch_count (w_mm),
    .first_mismatch_adr (w_fma), .addr_seq_err (w_seq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0;
    m_sel = '0; m_cti = 3'b000; m_bte = 2'b00;
  endtask

  // Seed A5A5_0000 with the byte offset bits cleared.
  function automatic logic [31:0] pat_m(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  task automatic classic(input string tag, input logic we_v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we_v; m_adr = a; m_dat = d; m_sel = s;
    m_cti = 3'b000; m_bte = 2'b00;
    tick;
    check_eq({tag, "_ack"}, {31'd0, ack}, 32'd1);
    if (!we_v) check_eq({tag, "_dat"}, dat_o, exp_rd);
    tick;
    bus_idle;
    check_eq({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
    tick;
  endtask

  // Master drives bus_a[k] per beat; data checked against pat(exp_a[k]).
  // Ack observations are shifted into a word, ending with the cycle after the last beat.
  task automatic burst_rd(input string tag, input int n, input logic [1:0] b,
                          input logic [31:0] exp_pat);
    int k;
    int cyc_n;
    logic prev;
    logic [31:0] pat_r;
    k = 0; cyc_n = 0; prev = 1'b0; pat_r = '0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_bte = b; m_adr = bus_a[0];
    m_cti = (n == 1) ? 3'b111 : 3'b010;
    while (k < n && cyc_n < 40) begin
      tick;
      cyc_n++;
      if (prev) begin
        k++;
        if (k < n) begin
          m_adr = bus_a[k];
          m_cti = (k == n - 1) ? 3'b111 : 3'b010;
        end else begin
          bus_idle;
        end
      end
      pat_r = {pat_r[30:0], ack};
      if (ack && k < n) check_eq({tag, "_dat"}, dat_o, pat_m(exp_a[k]));
      prev = ack;
    end
    check_eq({tag, "_beats"}, k, n);
    check_eq({tag, "_acks"}, pat_r, exp_pat);
    bus_idle;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle;
    tick;
    tick;
    rst = 1'b0;
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_rty", {31'd0, rty}, 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_bc", bc, 32'd0);
    check_eq("rst_mm", {16'd0, mm}, 32'd0);
    check_eq("rst_seq", {31'd0, seq}, 32'd0);
    tick;

    // Classic read
    classic("cl_rd", 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'hA5A5_0010);
    check_eq("cl_rd_bc", bc, 32'd1);

    // Linear 8-beat read burst
    for (int i = 0; i < 8; i++) begin
      bus_a[i] = 32'h100 + 32'(4 * i);
      exp_a[i] = bus_a[i];
    end
`ifdef WB_PATTERN_SLAVE_STALL_EN
    burst_rd("lin8", 8, 2'b00, 32'h0000_03DE);
`else
    burst_rd("lin8", 8, 2'b00, 32'h0000_01FE);
`endif
    check_eq("lin8_bc", bc, 32'd9);
    check_eq("lin8_seq", {31'd0, seq}, 32'd0);

    // Wrap-4 from 0x208
    bus_a[0] = 32'h208; bus_a[1] = 32'h20C; bus_a[2] = 32'h200; bus_a[3] = 32'h204;
    for (int i = 0; i < 4; i++) exp_a[i] = bus_a[i];
    burst_rd("wrap4", 4, 2'b01, 32'h0000_001E);
    check_eq("wrap4_seq", {31'd0, seq}, 32'd0);

    // Wrap-8 from 0x21C
    bus_a[0] = 32'h21C; bus_a[1] = 32'h200; bus_a[2] = 32'h204; bus_a[3] = 32'h208;
    for (int i = 0; i < 4; i++) exp_a[i] = bus_a[i];
    burst_rd("wrap8", 4, 2'b10, 32'h0000_001E);
    check_eq("wrap8_seq", {31'd0, seq}, 32'd0);
    check_eq("wrap8_bc", bc, 32'd17);

    // Master strays on beat 2; responder keeps its predicted sequence
    bus_a[0] = 32'h300; bus_a[1] = 32'h304; bus_a[2] = 32'h30C; bus_a[3] = 32'h30C;
    exp_a[0] = 32'h300; exp_a[1] = 32'h304; exp_a[2] = 32'h308; exp_a[3] = 32'h30C;
    burst_rd("seqbad", 4, 2'b00, 32'h0000_001E);
    check_eq("seqbad_seq", {31'd0, seq}, 32'd1);

    // Write compare
    classic("wr_bad", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 32'd0);
    check_eq("wr_bad_mm", {16'd0, mm}, 32'd1);
    check_eq("wr_bad_fma", fma, 32'h40);
    classic("wr_ok", 1'b1, 32'h44, 32'hA5A5_0044, 4'b1111, 32'd0);
    check_eq("wr_ok_mm", {16'd0, mm}, 32'd1);
    classic("wr_nosel", 1'b1, 32'h48, 32'h1234_5678, 4'b0000, 32'd0);
    check_eq("wr_nosel_mm", {16'd0, mm}, 32'd1);
    classic("wr_bad2", 1'b1, 32'h80, 32'h0000_0000, 4'b1000, 32'd0);
    check_eq("wr_bad2_mm", {16'd0, mm}, 32'd2);
    check_eq("wr_bad2_fma", fma, 32'h40);
    check_eq("wr_bc", bc, 32'd25);

    // Out-of-window access
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0001_0000; m_sel = 4'hF;
    tick;
    check_eq("err_hi", {31'd0, err}, 32'd1);
    check_eq("err_noack", {31'd0, ack}, 32'd0);
    tick;
    bus_idle;
    check_eq("err_lo", {31'd0, err}, 32'd0);
    check_eq("err_bc", bc, 32'd25);
    tick;

    // Reset in the middle of a burst
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h400; m_cti = 3'b010; m_sel = 4'hF;
    tick;
    tick;
    m_adr = 32'h404;
    check_eq("mid_ack", {31'd0, ack}, 32'd1);
    check_eq("mid_bc", bc, 32'd26);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus_idle;
    check_eq("mrst_ack", {31'd0, ack}, 32'd0);
    check_eq("mrst_dat", dat_o, 32'd0);
    check_eq("mrst_bc", bc, 32'd0);
    check_eq("mrst_mm", {16'd0, mm}, 32'd0);
    check_eq("mrst_fma", fma, 32'd0);
    check_eq("mrst_seq", {31'd0, seq}, 32'd0);
    tick;

    // Wait states (second instance, WAIT_CYCLES=2): ack three cycles after stb
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h20; m_sel = 4'hF; m_cti = 3'b000;
    tick;
    check_eq("wait_e0", {31'd0, w_ack}, 32'd0);
    tick;
    check_eq("wait_e1", {31'd0, w_ack}, 32'd0);
    tick;
    check_eq("wait_ack", {31'd0, w_ack}, 32'd1);
    check_eq("wait_dat", w_dat_o, 32'hA5A5_0020);
    tick;
    bus_idle;
    check_eq("wait_ack_low", {31'd0, w_ack}, 32'd0);
    check_eq("wait_bc", w_bc, 32'd1);
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_pattern_slave.md
Name: wb_pattern_slave

Overview:
- Wishbone B3 responder (slave) that terminates the DMA engine's master bus in lab/bring-up builds, replacing real memory.
- Reads return an address-derived pattern; writes are checked against the same pattern, and mismatches are counted.
- Supports classic cycles and incrementing bursts (linear and wrap-4/8/16), so DMA transfers can be self-checked without external memory.
- Sits on the engine-side WB bus; the existing debug/ILA block can probe its ports unchanged.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address of the response window.
- ADDR_WIDTH, 16: window is 2^ADDR_WIDTH bytes; range 4..31.
- WAIT_CYCLES, 0: idle cycles inserted before the first ack of each cycle or burst; range 0..15.
- SEED, 32'hA5A5_0000: pattern seed.
- STALL_PERIOD, 4: used only with the optional feature; range 2..255.

Ports:
- wb_clk  in  1  bus clock
- wb_rst  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_cti_i  in  3  cycle type identifier
- wb_bte_i  in  2  burst type extension
- wb_sel_i  in  4  byte lane selects
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error (address outside window)
- wb_rty_o  out  1  retry; tied 0
- beat_count  out  32  acked beats, wraps at 2^32
- mismatch_count  out  16  write-compare failures, saturates at 16'hFFFF
- first_mismatch_adr  out  32  address of the first failing write
- addr_seq_err  out  1  sticky: master's address differed from the predicted burst address

Behaviour:
- Reset is synchronous on wb_rst and takes effect on the next edge, including mid-burst. All outputs go to 0 and the FSM enters IDLE.
- Pattern: pat(A) = {A[31:2],2'b00} ^ SEED.
- In window: (adr - BASE_ADDR) < 2^ADDR_WIDTH, evaluated on the first beat only.
- FSM states: IDLE, WAIT, CLASSIC, BURST, ERR.
- IDLE:
  - cyc&stb out of window -> ERR.
  - cyc&stb in window with WAIT_CYCLES>0 -> WAIT.
  - cyc&stb in window, WAIT_CYCLES=0, cti=3'b010 -> BURST.
  - cyc&stb in window, WAIT_CYCLES=0, any other cti -> CLASSIC.
- WAIT: counts WAIT_CYCLES cycles, then goes to CLASSIC or BURST using the cti captured in IDLE. If cyc drops -> IDLE.
- Timing: all outputs are registered. First ack appears 1+WAIT_CYCLES cycles after stb is first seen.
- CLASSIC: ack high for exactly one cycle, then IDLE with ack low for at least one cycle. A held stb is not double-acked.
- BURST:
  - ack stays high every cycle while cyc&stb.
  - Internal address register advances each acked beat by 4 bytes, per bte: 00 linear; 01/10/11 wrap within 16/32/64-byte-aligned blocks (only bits [3:2]/[4:2]/[5:2] change).
  - The beat acked with cti=3'b111 is the last; ack is low the next cycle and the FSM returns to IDLE.
  - cyc or stb low mid-burst -> ack low next cycle, FSM to IDLE. Un-acked beats do not count.
- Reads: wb_dat_o = pat(current beat address), valid whenever ack is high. In BURST the address comes from the internal predicted register; the first beat uses the captured wb_adr_i.
- Writes (each acked beat): compare only lanes where sel=1 against pat(addr). On any differing lane, mismatch_count is incremented; the first such event latches first_mismatch_adr. sel=4'b0000 never mismatches.
- Address prediction: on every acked burst beat after the first, wb_adr_i != predicted address sets addr_seq_err, which is sticky until reset. Data and response still follow the predicted address.
- ERR: wb_err_o high for one cycle, then IDLE with err low one cycle. beat_count does not advance on err.
- beat_count increments once per ack, for both reads and writes.

Optional Feature:
- Macro: WB_PATTERN_SLAVE_STALL_EN.
- Defined: in BURST, after every STALL_PERIOD acked beats, ack is forced low for one cycle and the beat is then acked. The burst address does not advance during the stall.
- Undefined: bursts ack continuously. STALL_PERIOD is ignored and no stall logic is synthesised.

Decomposition:
- Shared package wb_pkg holds:
  - CTI constants CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111.
  - BTE constants LINEAR, WRAP4, WRAP8, WRAP16.
  - The FSM state typedef.
  - The pattern function.
- One sub-module, wb_burst_adr_gen: combinational next address from (addr, bte). Reusable by the engine side.

Test Plan:
- Classic read at 32'h0000_0010, WAIT_CYCLES=0 -> ack one cycle after stb; dat_o=32'hA5A5_0010; beat_count=1; ack low the following cycle.
- Linear INCR read burst of 8 beats from 32'h100, last beat with cti=111 -> 8 consecutive acks; data pat(0x100..0x11C); ack low after the last beat.
- WRAP4 burst starting at 32'h0000_0208 -> addresses 0x208, 0x20C, 0x200, 0x204; addr_seq_err stays 0 when the master follows the wrap.
- Write of 32'hDEAD_BEEF at 0x40 with sel=4'b0011, where pat low half is 0x0040 -> mismatch_count=1, first_mismatch_adr=0x40. A correct write after it -> count unchanged.
- Read at 32'h0001_0000 (outside window, ADDR_WIDTH=16) -> err_o one cycle, no ack, beat_count unchanged. wb_rst asserted mid-burst -> all outputs 0 on the next edge.
- With WB_PATTERN_SLAVE_STALL_EN, STALL_PERIOD=4, 8-beat burst -> ack pattern 1111 0 1111; data contiguous across the stall.
